seq_multiplier: RTL

Parametrised sequential shift-add multiplier: the next generation of the team's fixed 8-bit shift-add unit. Captures two WIDTH-bit operands on a start handshake, produces a 2*WIDTH-bit product after a fixed WIDTH-cycle iteration, and signals completion with a one-cycle done pulse. When the signed option is compiled in, it also performs two's-complement multiplication (radix-2 Booth). It sits as a multi-cycle arithmetic slave beside the datapath controller.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_step.sv | 47 ++++
 rtl/seq_multiplier.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// The SIGNED_MULT_EN build option is handled in mult_step and seq_multiplier.
package mult_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the iteration counter as clog2(WIDTH+1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add iteration on {A,Q}. With SIGNED_MULT_EN defined
// it adds the radix-2 Booth recoding (q_m1, subtractor, arithmetic shift).
module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mc,
`ifdef SIGNED_MULT_EN
  input  logic             q_m1,
  input  logic             sgn,
  output logic             q_m1_next,
`endif
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;

`ifdef SIGNED_MULT_EN
  logic [WIDTH:0] mc_ext;

  always_comb begin
    mc_ext = {sgn & mc[WIDTH-1], mc};
    sum    = a;
    if (sgn) begin
      if ({q[0], q_m1} == 2'b01) begin
        sum = a + mc_ext;
      end else if ({q[0], q_m1} == 2'b10) begin
        sum = a - mc_ext;
      end
    end else if (q[0]) begin
      sum = a + mc_ext;
    end
    // Arithmetic shift in signed mode, logical otherwise; Q[0] drops into q_m1.
    {a_next, q_next, q_m1_next} = {sgn & sum[WIDTH], sum, q};
  end
`else
  always_comb begin
    sum              = q[0] ? (a + {1'b0, mc}) : a;
    {a_next, q_next} = {1'b0, sum, q[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH-cycle shift-add multiplier with start/busy/done handshake.
// Define SIGNED_MULT_EN to add the signed_mode port and Booth datapath.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   MP,
  input  logic [WIDTH-1:0]   MC,
`ifdef SIGNED_MULT_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero_flag
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_multiplier: WIDTH out of legal range");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] mc_r;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [2*WIDTH-1:0] prod_c;
  logic             accept_c;

`ifdef SIGNED_MULT_EN
  logic qm1_r;
  logic sgn_r;
  logic qm1_nxt;
`endif

  mult_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_r),
    .q         (q_r),
    .mc        (mc_r),
`ifdef SIGNED_MULT_EN
    .q_m1      (qm1_r),
    .sgn       (sgn_r),
    .q_m1_next (qm1_nxt),
`endif
    .a_next    (a_nxt),
    .q_next    (q_nxt)
  );

  assign prod_c = {a_nxt[WIDTH-1:0], q_nxt};

  // The edge leaving DONE doubles as an accepting edge, giving WIDTH+1 throughput.
  assign accept_c = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
      zero_flag <= 1'b1;
      cnt       <= '0;
      a_r       <= '0;
      q_r       <= '0;
      mc_r      <= '0;
`ifdef SIGNED_MULT_EN
      qm1_r     <= 1'b0;
      sgn_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        state <= RUN;
        busy  <= 1'b1;
        cnt   <= CW'(WIDTH);
        a_r   <= '0;
        q_r   <= MP;
        mc_r  <= MC;
`ifdef SIGNED_MULT_EN
        qm1_r <= 1'b0;
        sgn_r <= signed_mode;
`endif
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            a_r <= a_nxt;
            q_r <= q_nxt;
`ifdef SIGNED_MULT_EN
            qm1_r <= qm1_nxt;
`endif
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state     <= DONE;
              done      <= 1'b1;
              product   <= prod_c;
              zero_flag <= (prod_c == '0);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
